// File: rtl/sipo_deser.sv
// sipo_deser: serial-to-parallel word receiver.
//
// Collects single-bit samples qualified by a_valid, aligns to words using
// the sof marker, and presents each completed W-bit word on a registered
// valid/ready holding register.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   a          serial data bit
//   a_valid    a is sampled on this edge when high
//   sof        start of frame (qualified by a_valid); a is bit 0 of a new word
//   y          received word (holding register)
//   y_valid    y holds an unconsumed word
//   y_ready    consumer takes y when y_valid && y_ready
//   overrun    one-cycle pulse: a completed word was dropped (slot busy)
//   frame_err  one-cycle pulse: a partial word was discarded by sof
module sipo_deser #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a,
  input  logic         a_valid,
  input  logic         sof,
  output logic [W-1:0] y,
  output logic         y_valid,
  input  logic         y_ready,
  output logic         overrun,
  output logic         frame_err
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W);

  typedef enum logic {HUNT, RECV} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  sr;

  logic          accept;
  logic          resync;
  logic [CW-1:0] cnt_base;
  logic [CW-1:0] cnt_inc;
  logic          done;
  logic          slot_free;
  logic [W-1:0]  sr_next;

  // In HUNT only a sof bit is taken; in RECV every qualified bit is.
  assign accept    = a_valid && (sof || (state == RECV));
  // sof always restarts the word count; old shift contents need no clearing
  // because W further shifts push them out before the word completes.
  assign cnt_base  = sof ? '0 : cnt;
  assign cnt_inc   = cnt_base + CW'(1);
  assign done      = accept && (cnt_inc == CNT_LAST);
  // A sof arriving mid-word in RECV throws away the partial word.
  assign resync    = a_valid && sof && (state == RECV) && (cnt != '0);
  assign slot_free = !y_valid || y_ready;

  generate
    if (W == 1) begin : g_w1
      assign sr_next = a;
    end else if (MSB_FIRST) begin : g_msb
      assign sr_next = {sr[W-2:0], a};
    end else begin : g_lsb
      assign sr_next = {a, sr[W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      cnt       <= '0;
      sr        <= '0;
      y         <= '0;
      y_valid   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= resync;

      if (accept) begin
        state <= RECV;
        sr    <= sr_next;
        // Wrap at W so back-to-back words stream without another sof.
        cnt   <= done ? '0 : cnt_inc;
      end

      if (done) begin
        if (slot_free) begin
          y       <= sr_next;
          y_valid <= 1'b1;
        end else begin
          // Holding register still owned by the consumer: drop the new word.
          overrun <= 1'b1;
        end
      end else if (y_valid && y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
module tb_sipo_deser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         a;
  logic         a_valid;
  logic         sof;
  logic         y_ready;
  logic [W-1:0] y_m, y_l;
  logic         yv_m, yv_l, ov_m, ov_l, fe_m, fe_l;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  // MSB-first and LSB-first receivers share one input stream.
  sipo_deser #(.W(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .sof(sof),
    .y(y_m), .y_valid(yv_m), .y_ready(y_ready),
    .overrun(ov_m), .frame_err(fe_m));

  sipo_deser #(.W(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .sof(sof),
    .y(y_l), .y_valid(yv_l), .y_ready(y_ready),
    .overrun(ov_l), .frame_err(fe_l));

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the partial word is a list of received bits; a word
  // is assembled by bit index once W bits are present.
  bit           mbits[$];
  bit           in_frame;
  logic [W-1:0] e_y, e_yl, wm, wl;
  bit           e_yv, e_ov, e_fe, mdone;

  always @(posedge clk) begin
    if (rst) begin
      mbits.delete();
      in_frame = 0;
      e_y = '0; e_yl = '0; e_yv = 0; e_ov = 0; e_fe = 0;
    end else begin
      e_ov  = 0;
      e_fe  = 0;
      mdone = 0;
      if (a_valid) begin
        if (sof) begin
          if (in_frame && mbits.size() != 0) e_fe = 1;
          mbits.delete();
          mbits.push_back(a);
          in_frame = 1;
        end else if (in_frame) begin
          mbits.push_back(a);
        end
        if (mbits.size() == W) begin
          mdone = 1;
          for (int i = 0; i < W; i++) begin
            wm[W-1-i] = mbits[i];
            wl[i]     = mbits[i];
          end
          mbits.delete();
        end
      end
      if (mdone) begin
        if (!e_yv || y_ready) begin
          e_y = wm; e_yl = wl; e_yv = 1;
        end else begin
          e_ov = 1;
        end
      end else if (e_yv && y_ready) begin
        e_yv = 0;
      end
    end
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("y_msb",     32'(y_m),  32'(e_y));
      cmp("y_lsb",     32'(y_l),  32'(e_yl));
      cmp("y_valid",   32'(yv_m), 32'(e_yv));
      cmp("y_valid_l", 32'(yv_l), 32'(e_yv));
      cmp("overrun",   32'(ov_m), 32'(e_ov));
      cmp("overrun_l", 32'(ov_l), 32'(e_ov));
      cmp("frame_err", 32'(fe_m), 32'(e_fe));
      cmp("frame_err_l", 32'(fe_l), 32'(e_fe));
    end
  end

  // Pulse counters pin pulse occurrences independently of the model.
  int ov_cnt = 0;
  int fe_cnt = 0;
  always @(negedge clk) begin
    if (ov_m) ov_cnt++;
    if (fe_m) fe_cnt++;
  end

  task automatic drive(input bit b, input bit s);
    @(negedge clk);
    a = b; a_valid = 1'b1; sof = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      a = 1'b0; a_valid = 1'b0; sof = 1'b0;
    end
  endtask

  task automatic send8(input logic [7:0] w, input bit s);
    for (int i = 7; i >= 0; i--) drive(w[i], s && (i == 7));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; a = 1'b0; a_valid = 1'b0; sof = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] w;
  int         ov0, fe0;

  initial begin
    rst = 1'b1; a = 1'b0; a_valid = 1'b0; sof = 1'b0; y_ready = 1'b1;
    @(negedge clk);
    chk_en = 1;
    cmp("rst_y",  32'(y_m),  32'h0);
    cmp("rst_yv", 32'(yv_m), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: A5, gapless, consumer ready
    send8(8'hA5, 1'b1);
    cmp("t1_yv_before", 32'(yv_m), 32'h0);
    idle(1);
    cmp("t1_y",  32'(y_m),  32'hA5);
    cmp("t1_yl", 32'(y_l),  32'hA5);
    cmp("t1_yv", 32'(yv_m), 32'h1);
    cmp("t1_ov", 32'(ov_m), 32'h0);
    cmp("t1_fe", 32'(fe_m), 32'h0);
    idle(1);
    cmp("t1_yv_drop", 32'(yv_m), 32'h0);

    // 2: A5 with a 3-cycle gap between bits 4 and 5
    w = 8'hA5;
    for (int i = 7; i >= 4; i--) drive(w[i], i == 7);
    idle(3);
    for (int i = 3; i >= 0; i--) drive(w[i], 1'b0);
    cmp("t2_yv_before", 32'(yv_m), 32'h0);
    idle(1);
    cmp("t2_y",  32'(y_m),  32'hA5);
    cmp("t2_yv", 32'(yv_m), 32'h1);

    // 3: leading bits without sof are ignored after reset
    do_reset();
    drive(1'b1, 1'b0); drive(1'b1, 1'b0); drive(1'b0, 1'b0);
    send8(8'hA5, 1'b1);
    idle(1);
    cmp("t3_y",  32'(y_m),  32'hA5);
    cmp("t3_yv", 32'(yv_m), 32'h1);
    cmp("t3_fe_cnt", 32'(fe_cnt), 32'h0);
    idle(1);

    // 4: backpressure, second word dropped
    y_ready = 1'b0;
    ov0 = ov_cnt;
    send8(8'h3C, 1'b1);
    send8(8'hC3, 1'b0);
    cmp("t4_y_first", 32'(y_m), 32'h3C);
    idle(1);
    cmp("t4_ov",  32'(ov_m), 32'h1);
    cmp("t4_y",   32'(y_m),  32'h3C);
    cmp("t4_yv",  32'(yv_m), 32'h1);
    idle(1);
    cmp("t4_ov_end", 32'(ov_m), 32'h0);
    cmp("t4_y_hold", 32'(y_m),  32'h3C);
    cmp("t4_ov_cnt", 32'(ov_cnt - ov0), 32'h1);

    // 5: consume on the same edge the next word completes
    w = 8'h5A;
    for (int i = 7; i >= 1; i--) drive(w[i], i == 7);
    drive(w[0], 1'b0);
    y_ready = 1'b1;
    cmp("t5_y_old", 32'(y_m), 32'h3C);
    idle(1);
    cmp("t5_y",  32'(y_m),  32'h5A);
    cmp("t5_yv", 32'(yv_m), 32'h1);
    cmp("t5_ov", 32'(ov_m), 32'h0);
    idle(1);
    cmp("t5_yv_drop", 32'(yv_m), 32'h0);
    cmp("t5_y_keep",  32'(y_m),  32'h5A);

    // 6: resync mid-word
    fe0 = fe_cnt;
    drive(1'b1, 1'b1); drive(1'b0, 1'b0); drive(1'b1, 1'b0);
    send8(8'h81, 1'b1);
    idle(1);
    cmp("t6_y",  32'(y_m),  32'h81);
    cmp("t6_fe_cnt", 32'(fe_cnt - fe0), 32'h1);

    // 7: bit order
    send8(8'h80, 1'b1);
    idle(1);
    cmp("t7_y_msb", 32'(y_m), 32'h80);
    cmp("t7_y_lsb", 32'(y_l), 32'h01);

    // 8: reset mid-word then a full word
    ov0 = ov_cnt; fe0 = fe_cnt;
    drive(1'b1, 1'b1); drive(1'b0, 1'b0); drive(1'b1, 1'b0);
    drive(1'b1, 1'b0); drive(1'b0, 1'b0);
    do_reset();
    cmp("t8_rst_y", 32'(y_m), 32'h0);
    send8(8'hFF, 1'b1);
    idle(1);
    cmp("t8_y",  32'(y_m),  32'hFF);
    cmp("t8_yv", 32'(yv_m), 32'h1);
    idle(2);
    cmp("t8_fe_cnt", 32'(fe_cnt - fe0), 32'h0);
    cmp("t8_ov_cnt", 32'(ov_cnt - ov0), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
Serial-to-parallel receiver at the far end of the serial bit lines driven by the pipeline shift/delay stages.
- Collects single-bit samples qualified by a valid strobe.
- Aligns to words using a start-of-frame marker.
- Presents each completed W-bit word on a registered valid/ready output interface.
- Flags words dropped under backpressure and frames broken by an early resync.

Parameters:
W, 8, word width in bits (legal range 1..32)
MSB_FIRST, 1, 1 = first received bit lands in y[W-1]; 0 = first received bit lands in y[0]

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
a  input  1  serial data bit
a_valid  input  1  a is sampled on this clock edge when high
sof  input  1  start of frame; qualified by a_valid; marks a as bit 0 of a new word
y  output  W  received word (holding register)
y_valid  output  1  y holds an unconsumed word
y_ready  input  1  consumer accepts y this cycle when y_valid && y_ready
overrun  output  1  one-cycle pulse: a completed word was dropped
frame_err  output  1  one-cycle pulse: a partial word was discarded by sof

Behaviour:
- Reset (rst=1 at a rising edge):
  - y=0, y_valid=0, overrun=0, frame_err=0.
  - Bit counter cnt=0; shift register cleared; state=HUNT.
  - Reset mid-word discards the partial word with no error pulse.
- State HUNT:
  - a_valid && !sof: bit ignored.
  - a_valid && sof: bit accepted as the first bit of a word; cnt=1; go to RECV.
- State RECV:
  - a_valid && !sof: bit appended; cnt++.
  - a_valid && sof && cnt!=0: partial word discarded; frame_err pulses next cycle; this bit starts a new word; cnt=1.
  - a_valid && sof && cnt==0: normal word start; no error.
  - a_valid=0: no change. Gaps of any length are allowed mid-word.
- Word completion:
  - Occurs on the edge where the accepted bit makes cnt reach W. cnt wraps to 0 and the state stays RECV, so back-to-back words stream without further sof.
  - With W=1, every accepted bit completes a word, including the sof bit.
- Bit order:
  - MSB_FIRST=1: shift left, new bit enters at the LSB; the first bit ends in y[W-1].
  - MSB_FIRST=0: shift right, new bit enters at the MSB; the first bit ends in y[0].
- Output handoff (all outputs are registered):
  - slot_free = !y_valid || y_ready, evaluated in the completion cycle.
  - Completion && slot_free: y loads the word and y_valid=1 in the following cycle. Latency is one clock after the edge sampling the last bit.
  - Completion && !slot_free: word dropped; y and y_valid unchanged; overrun=1 for exactly one cycle.
  - y_valid && y_ready with no completion: y_valid=0 next cycle; y retains its value.
  - y is stable while y_valid && !y_ready.
- Simultaneous events:
  - Consume and complete in the same cycle: the new word loads; y_valid stays 1; no overrun.
  - sof-resync and completion cannot coincide except when W=1. In that case the completion is normal and there is no frame_err.
- Counter width is clog2(W+1). The counter never exceeds W-1 between edges.

Test Plan:
- W=8, MSB_FIRST=1, y_ready=1; send 1,0,1,0,0,1,0,1 with sof on the first bit and a_valid held high -> y=8'hA5 and y_valid=1 for one cycle, exactly one clock after the 8th bit edge; overrun=0, frame_err=0.
- Same word with a_valid low for 3 cycles between bits 4 and 5 -> y=8'hA5; y_valid rises one clock after the 8th accepted bit.
- Bits 1,1,0 with a_valid=1 and sof=0 from reset, then 0xA5 with sof -> the three leading bits are ignored; y=8'hA5.
- y_ready=0; stream 0x3C then 0xC3 back-to-back -> y=8'h3C with y_valid held; overrun pulses one cycle after the 16th bit; y stays 8'h3C. Raise y_ready -> y_valid drops the next cycle.
- Consumer asserts y_ready on the same edge the next word completes -> y changes 0x3C→0x5A with y_valid continuously high; no overrun.
- Resync: 3 bits, then sof followed by 0x81 -> frame_err one-cycle pulse; y=8'h81.
- MSB_FIRST=0: send 1,0,0,0,0,0,0,0 -> y=8'h01.
- rst after 5 bits, then a full 0xFF with sof -> no error pulses; y=8'hFF.
